// File: rtl/eic_arb_pkg.sv
// Shared constants for the EIC interrupt arbiter: default sizing, FSM
// state encodings and the fixed ID reported for the urgent source.
package eic_arb_pkg;

  localparam int unsigned DEF_NUM_SRC = 8;
  localparam int unsigned DEF_ID_W    = 3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_HOLDOFF = 2'd2;

  localparam int unsigned URGENT_ID = 0;

endpackage

// File: rtl/eic_priority_encoder.sv
// Combinational find-first-set: reports the lowest set index of req_i.
module eic_priority_encoder #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned ID_W    = 3
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic               found_c_o,
  output logic [ID_W-1:0]    idx_c_o
);

  // Scan high to low so the lowest set index is the last one written.
  always_comb begin
    found_c_o = |req_i;
    idx_c_o   = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (req_i[i]) idx_c_o = ID_W'(i);
    end
  end

endmodule

// File: rtl/eic_priority_arbiter.sv
// Shares the processor EIC interrupt channel between NUM_SRC edge-triggered
// sources plus one urgent source, with fixed priority and a req/ack handshake.
module eic_priority_arbiter
  import eic_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC = DEF_NUM_SRC,
  parameter int unsigned ID_W    = DEF_ID_W
) (
  input  logic               Sys_Clock,
  input  logic               Sys_Reset,
  input  logic [NUM_SRC-1:0] Src_IntReq,
  input  logic               Urgent_Req,
  input  logic [NUM_SRC-1:0] Int_Enable,
  input  logic               Global_En,
  input  logic [NUM_SRC-1:0] Pend_Clear,
  output logic [NUM_SRC-1:0] Pending,
  output logic               Urgent_Pending,
  output logic               EIC_IntReq,
  output logic [ID_W-1:0]    EIC_IntId,
  output logic               EIC_IntUrgent,
  input  logic               EIC_IntAck
);

  logic [1:0]         state_q, state_d;
  logic               req_q, req_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               urg_q, urg_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic               upend_q, upend_d;
  logic [NUM_SRC-1:0] prev_q;
  logic               uprev_q;

  logic [NUM_SRC-1:0] set_c, elig_c, win_oh_c, ack_clr_c;
  logic               uset_c, ack_c, win_elig_c;
  logic               enc_found_c;
  logic [ID_W-1:0]    enc_idx_c;

  assign set_c  = Src_IntReq & ~prev_q;
  assign uset_c = Urgent_Req & ~uprev_q;
  assign elig_c = pend_q & Int_Enable & {NUM_SRC{Global_En}};
  assign ack_c  = (state_q == ST_REQ) && EIC_IntAck;

  // One-hot view of the latched winner, used for ack clear and withdraw check.
  always_comb begin
    win_oh_c = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      win_oh_c[i] = (id_q == ID_W'(i));
    end
  end

  assign ack_clr_c  = (ack_c && !urg_q) ? win_oh_c : '0;
  assign win_elig_c = urg_q ? upend_q : |(elig_c & win_oh_c);

  // A new edge beats any clear landing in the same cycle.
  assign pend_d  = set_c | (pend_q & ~(Pend_Clear | ack_clr_c));
  assign upend_d = uset_c | (upend_q & ~(ack_c && urg_q));

  eic_priority_encoder #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_enc (
    .req_i     (elig_c),
    .found_c_o (enc_found_c),
    .idx_c_o   (enc_idx_c)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    id_d    = id_q;
    urg_d   = urg_q;
    case (state_q)
      ST_IDLE: begin
        if (upend_q) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          id_d    = ID_W'(URGENT_ID);
          urg_d   = 1'b1;
        end else if (enc_found_c) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          id_d    = enc_idx_c;
          urg_d   = 1'b0;
        end
      end
      ST_REQ: begin
        if (EIC_IntAck) begin
          state_d = ST_HOLDOFF;
          req_d   = 1'b0;
        end else if (!win_elig_c) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
        end
      end
      ST_HOLDOFF: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Sys_Clock) begin
    if (Sys_Reset) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      id_q    <= '0;
      urg_q   <= 1'b0;
      pend_q  <= '0;
      upend_q <= 1'b0;
      prev_q  <= '0;
      uprev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      id_q    <= id_d;
      urg_q   <= urg_d;
      pend_q  <= pend_d;
      upend_q <= upend_d;
      prev_q  <= Src_IntReq;
      uprev_q <= Urgent_Req;
    end
  end

  assign Pending        = pend_q;
  assign Urgent_Pending = upend_q;
  assign EIC_IntReq     = req_q;
  assign EIC_IntId      = id_q;
  assign EIC_IntUrgent  = urg_q;

endmodule

// File: tb/tb_eic_priority_arbiter.sv
// Directed bench for eic_priority_arbiter with hand-computed expectations.
module tb_eic_priority_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] src;
  logic       urq;
  logic [7:0] en;
  logic       gen;
  logic [7:0] pclr;
  logic [7:0] pend;
  logic       upend;
  logic       ireq;
  logic [2:0] iid;
  logic       iurg;
  logic       ack;

  int total = 0;
  int bad   = 0;
  int cnt;

  always #5 clk = ~clk;

  eic_priority_arbiter #(.NUM_SRC(8), .ID_W(3)) dut (
    .Sys_Clock      (clk),
    .Sys_Reset      (rst),
    .Src_IntReq     (src),
    .Urgent_Req     (urq),
    .Int_Enable     (en),
    .Global_En      (gen),
    .Pend_Clear     (pclr),
    .Pending        (pend),
    .Urgent_Pending (upend),
    .EIC_IntReq     (ireq),
    .EIC_IntId      (iid),
    .EIC_IntUrgent  (iurg),
    .EIC_IntAck     (ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input logic r, input logic [2:0] id, input logic u);
    chk({tag, "_req"}, 32'(ireq), 32'(r));
    if (r) begin
      chk({tag, "_id"}, 32'(iid), 32'(id));
      chk({tag, "_urg"}, 32'(iurg), 32'(u));
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; src = '0; urq = 1'b0; en = '0; gen = 1'b0; pclr = '0; ack = 1'b0;
    tick(); tick();
    chk("rst_pend", 32'(pend), 32'h0);
    chk("rst_upend", 32'(upend), 32'h0);
    chk("rst_req", 32'(ireq), 32'h0);
    chk("rst_id", 32'(iid), 32'h0);
    chk("rst_urg", 32'(iurg), 32'h0);
    rst = 1'b0; en = 8'hFF; gen = 1'b1;
    tick();

    // Single source, then level held high must not retrigger
    src[3] = 1'b1;
    tick();
    chk("s3_pend", 32'(pend), 32'h08);
    chk("s3_noreq_yet", 32'(ireq), 32'h0);
    tick();
    chk_req("s3_req", 1'b1, 3'd3, 1'b0);
    tick(); tick();
    chk_req("s3_hold", 1'b1, 3'd3, 1'b0);
    do_ack();
    chk("s3_ack_pend", 32'(pend), 32'h0);
    chk("s3_ack_req", 32'(ireq), 32'h0);
    tick();
    chk("s3_holdoff", 32'(ireq), 32'h0);
    cnt = 0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (ireq) cnt++;
    end
    chk("level_no_retrig", 32'(cnt), 32'h0);
    src[3] = 1'b0;
    tick();
    src[3] = 1'b1;
    tick();
    chk("s3_rearm_pend", 32'(pend), 32'h08);
    tick();
    chk_req("s3_rearm_req", 1'b1, 3'd3, 1'b0);
    do_ack();
    src[3] = 1'b0;
    tick(); tick();

    // Priority 2 over 5; urgent arrives while 5 is held and goes next
    src[5] = 1'b1; src[2] = 1'b1;
    tick();
    chk("p_pend", 32'(pend), 32'h24);
    tick();
    chk_req("p_first", 1'b1, 3'd2, 1'b0);
    do_ack();
    chk("p_ack_pend", 32'(pend), 32'h20);
    chk("p_ack_req", 32'(ireq), 32'h0);
    tick();
    chk("p_holdoff", 32'(ireq), 32'h0);
    tick();
    chk_req("p_second", 1'b1, 3'd5, 1'b0);
    urq = 1'b1; src[0] = 1'b1;
    tick();
    chk("u_pend", 32'(upend), 32'h1);
    chk_req("u_no_preempt", 1'b1, 3'd5, 1'b0);
    tick();
    chk_req("u_no_preempt2", 1'b1, 3'd5, 1'b0);
    do_ack();
    chk("u_ack_pend", 32'(pend), 32'h01);
    chk("u_ack_req", 32'(ireq), 32'h0);
    tick(); tick();
    chk_req("u_served", 1'b1, 3'd0, 1'b1);
    do_ack();
    chk("u_cleared", 32'(upend), 32'h0);
    tick(); tick();
    chk_req("s0_after_u", 1'b1, 3'd0, 1'b0);
    do_ack();
    src = '0; urq = 1'b0;
    tick(); tick();

    // Masking withdraws; re-enable reasserts
    src[1] = 1'b1;
    tick(); tick();
    chk_req("m_req", 1'b1, 3'd1, 1'b0);
    en = 8'hFD;
    tick();
    chk("m_withdraw", 32'(ireq), 32'h0);
    chk("m_pend_kept", 32'(pend), 32'h02);
    tick();
    chk("m_stay_low", 32'(ireq), 32'h0);
    en = 8'hFF;
    tick();
    chk_req("m_reassert", 1'b1, 3'd1, 1'b0);
    do_ack();
    src[1] = 1'b0;
    tick(); tick();

    // Global disable blocks ordinary sources but not urgent
    gen = 1'b0; urq = 1'b1; src[6] = 1'b1;
    tick();
    chk("g_upend", 32'(upend), 32'h1);
    tick();
    chk_req("g_urgent", 1'b1, 3'd0, 1'b1);
    do_ack();
    chk("g_ack_req", 32'(ireq), 32'h0);
    tick(); tick(); tick();
    chk("g_blocked", 32'(ireq), 32'h0);
    chk("g_pend6", 32'(pend), 32'h40);
    pclr = 8'h40;
    tick();
    pclr = '0; urq = 1'b0; src[6] = 1'b0; gen = 1'b1;
    chk("g_sw_clear", 32'(pend), 32'h0);
    tick();

    // Set beats clear; new edge during ack keeps the bit for another round
    src[4] = 1'b1; pclr = 8'h10;
    tick();
    pclr = '0;
    chk("sc_set_wins", 32'(pend), 32'h10);
    tick();
    chk_req("sc_req", 1'b1, 3'd4, 1'b0);
    src[4] = 1'b0;
    tick();
    src[4] = 1'b1;
    do_ack();
    chk("sc_ack_edge_pend", 32'(pend), 32'h10);
    chk("sc_ack_req", 32'(ireq), 32'h0);
    tick();
    chk("sc_holdoff", 32'(ireq), 32'h0);
    tick();
    chk_req("sc_rereq", 1'b1, 3'd4, 1'b0);
    do_ack();
    chk("sc_final_pend", 32'(pend), 32'h0);
    src[4] = 1'b0;
    tick(); tick();

    // Reset during REQ, lines held high through reset re-detect once
    src = 8'h81;
    tick();
    chk("r_pend", 32'(pend), 32'h81);
    tick();
    chk_req("r_req", 1'b1, 3'd0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_pend0", 32'(pend), 32'h0);
    chk("r_req0", 32'(ireq), 32'h0);
    chk("r_id0", 32'(iid), 32'h0);
    chk("r_urg0", 32'(iurg), 32'h0);
    chk("r_upend0", 32'(upend), 32'h0);
    tick();
    chk("r_redetect", 32'(pend), 32'h81);
    tick();
    chk_req("r_req_again", 1'b1, 3'd0, 1'b0);
    do_ack();
    chk("r_pend80", 32'(pend), 32'h80);
    tick(); tick();
    chk_req("r_req7", 1'b1, 3'd7, 1'b0);
    do_ack();
    chk("r_pend_none", 32'(pend), 32'h0);
    tick(); tick(); tick();
    chk("r_single_event", 32'(ireq), 32'h0);
    src = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eic_priority_arbiter.md
Name: eic_priority_arbiter

Overview:
- Interrupt scheduler for the external interrupt controller path. It shares the single processor interrupt channel (EIC_IntReq/EIC_IntId/EIC_IntAck) between NUM_SRC peripheral sources plus one urgent source.
- It latches rising edges into pending bits, applies the enable mask, and picks the highest-priority winner with fixed priority.
- It runs the request/acknowledge handshake with the processor and exposes pending state for the EIC register file.

Parameters:
NUM_SRC, 8, number of ordinary interrupt sources; index 0 is highest priority
ID_W, 3, width of EIC_IntId; must satisfy 2**ID_W >= NUM_SRC

Ports:
Sys_Clock  input  1  system clock; the only clock
Sys_Reset  input  1  synchronous, active-high reset
Src_IntReq  input  NUM_SRC  per-source interrupt lines, level; rising edge is the event
Urgent_Req  input  1  urgent source, level; rising edge is the event
Int_Enable  input  NUM_SRC  per-source enable mask from EIC register
Global_En  input  1  global enable for ordinary sources; urgent ignores it
Pend_Clear  input  NUM_SRC  software write-1-to-clear strobe, one cycle
Pending  output  NUM_SRC  raw pending bits, unmasked
Urgent_Pending  output  1  urgent pending bit
EIC_IntReq  output  1  interrupt request to processor
EIC_IntId  output  ID_W  winning source index; valid while EIC_IntReq=1
EIC_IntUrgent  output  1  winner is the urgent source; valid while EIC_IntReq=1
EIC_IntAck  input  1  processor acknowledge, single-cycle pulse

Behaviour:
- Reset:
  - Applied on the Sys_Clock edge when Sys_Reset=1.
  - Pending=0, Urgent_Pending=0, EIC_IntReq=0, EIC_IntId=0, EIC_IntUrgent=0, state=IDLE.
  - Edge-detect registers load 0, so a line already high when reset releases produces one event.
  - Reset mid-handshake aborts with no ack required.
- Edge detect:
  - prev <= Src_IntReq each cycle.
  - set[i] = Src_IntReq[i] & ~prev[i]. Urgent is handled the same way.
- Pending update per bit: next = set | (cur & ~clr), where clr = Pend_Clear[i] | ack_clear[i].
  - Set and clear in the same cycle: set wins, bit stays 1.
  - Events while a bit is already pending are merged; there is no counting.
- Eligibility:
  - elig = Pending & Int_Enable & {NUM_SRC{Global_En}}.
  - Urgent is eligible whenever Urgent_Pending=1.
- Priority: urgent first, then lowest eligible index.
- State machine (registered outputs):
  - IDLE:
    - If urgent is eligible: latch EIC_IntUrgent=1, EIC_IntId=0, assert EIC_IntReq, go to REQ.
    - Else if any elig: latch EIC_IntId=lowest index, EIC_IntUrgent=0, assert EIC_IntReq, go to REQ.
    - Else stay.
  - REQ:
    - EIC_IntReq=1 and EIC_IntId/EIC_IntUrgent are held stable; there is no preemption, including by urgent.
    - On EIC_IntAck: clear the winner's pending bit in the same edge, drop EIC_IntReq, go to HOLDOFF.
    - Withdraw: if there is no ack and the winner is no longer eligible (cleared by software, disabled, or Global_En=0 for an ordinary winner), drop EIC_IntReq and go to IDLE. Ack takes precedence over withdraw in the same cycle.
  - HOLDOFF:
    - One cycle with EIC_IntReq=0, which guarantees a visible deassert between requests.
    - Then go to IDLE.
- EIC_IntAck outside REQ is ignored.
- Latency:
  - A line rising before edge k gives Pending=1 after edge k.
  - EIC_IntReq=1 after edge k+1 if the arbiter is in IDLE.
  - After an ack at edge a, the next request is asserted no earlier than edge a+2.
- An edge of the winner's own source arriving in the ack cycle keeps its pending bit set, so it is served again.

Decomposition:
- Package eic_arb_pkg:
  - state enum {IDLE, REQ, HOLDOFF}
  - default NUM_SRC/ID_W constants
  - localparam URGENT_ID = '0
- Sub-module eic_priority_encoder: combinational find-first-set over NUM_SRC. Outputs are valid and an ID_W index.
- Everything else stays in eic_priority_arbiter.

Test Plan:
- Single source: Int_Enable=8'hFF, Global_En=1, Src_IntReq[3] rises at cycle 10 -> Pending=8'h08 after edge 10; EIC_IntReq=1 with EIC_IntId=3 after edge 11; EIC_IntAck pulse at cycle 14 -> Pending=0, EIC_IntReq=0 after edge 14; stays 0 through at least edge 15.
- Priority and ordering: sources 5 and 2 rise in the same cycle -> served as Id=2, then after ack and HOLDOFF, Id=5. Urgent rising while Id=5 is in REQ -> Id=5 held until ack, then EIC_IntUrgent=1 is served next, ahead of any other pending source.
- Masking and withdraw: source 1 in REQ, then Int_Enable[1] cleared -> EIC_IntReq drops next edge and Pending[1] stays 1. Re-enable -> request reasserts with Id=1. Global_En=0 with urgent pending -> urgent still requested.
- Simultaneous events: Pend_Clear[4] and a rising Src_IntReq[4] in the same cycle -> Pending[4]=1. Ack of Id=4 coinciding with a new edge on source 4 -> Pending[4] remains 1 and source 4 is re-requested after HOLDOFF.
- Reset mid-operation: Sys_Reset=1 for one edge while in REQ with Pending=8'h81 -> all outputs 0 next cycle. A line held high through reset is re-detected as one event.
- Level hold: a source held high for 50 cycles and acked once -> exactly one request, with no re-trigger until the line falls and rises again.
